// File: rtl/led_shift_ctrl_pkg.sv
// ------------------------------------------------------------------
// led_shift_ctrl_pkg : shared codes and seed constants for led_shift_ctrl
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package led_shift_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      ROT_L    = 2'b00,
      ROT_R    = 2'b01,
      PINGPONG = 2'b10,
      BLINK    = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      NORM = 2'b00,
      FAST = 2'b01,
      SLOW = 2'b10,
      HOLD = 2'b11
   } speed_t;

   localparam logic [7:0] SEED_LO  = 8'h01;
   localparam logic [7:0] SEED_HI  = 8'h80;
   localparam logic [7:0] SEED_ALL = 8'hFF;

   function automatic logic [7:0] seed_for(input mode_t mode);
      logic [7:0] seed;
      case (mode)
         ROT_R:   seed = SEED_HI;
         BLINK:   seed = SEED_ALL;
         default: seed = SEED_LO;
      endcase
      return seed;
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_shift_ctrl_step_timer.sv
// ------------------------------------------------------------------
// step_timer : 32-bit period counter emitting a one-cycle wrap pulse
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module step_timer (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [31:0] period,
   input  logic        run,
   input  logic        clear,
   output logic        wrap
);

   logic [31:0] r_cnt;
   logic        w_last;

   // >= keeps the counter from running away if period ever shrinks under it
   assign w_last = (r_cnt >= (period - 32'd1));
   assign wrap   = run && !clear && w_last;

   always_ff @(posedge clk_in) begin
      if (rst || clear) begin
         r_cnt <= 32'd0;
      end else if (run) begin
         r_cnt <= w_last ? 32'd0 : (r_cnt + 32'd1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/led_shift_ctrl.sv
// ------------------------------------------------------------------
// led_shift_ctrl : switch-selected LED rotate/ping-pong/blink sequencer
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module led_shift_ctrl
   import led_shift_ctrl_pkg::*;
#(
   parameter int unsigned BASE_DIV = 12_500_000,
   parameter int unsigned LED_W    = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [3:0]       sw,
   output logic [LED_W-1:0] led,
   output logic             step,
   output logic [1:0]       state_o
);

   localparam logic [31:0] P_NORM = 32'(BASE_DIV);
   localparam logic [31:0] P_FAST = ((BASE_DIV / 2) < 1) ? 32'd1 : 32'(BASE_DIV / 2);
   localparam logic [31:0] P_SLOW = 32'(BASE_DIV) * 32'd2;

   logic [3:0]       r_sw_meta;
   logic [3:0]       r_sw_s;
   logic [3:0]       r_sw_prev;
   state_t           r_state;
   state_t           w_next_state;
   logic [LED_W-1:0] r_led;
   logic             r_dir_left;
   logic             r_step;

   mode_t            w_mode;
   speed_t           w_speed;
   logic             w_mode_chg;
   logic             w_spd_chg;
   logic [31:0]      w_period;
   logic             w_run;
   logic             w_clear;
   logic             w_wrap;
   logic [LED_W-1:0] w_led_step;
   logic             w_dir_step;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_sw_meta <= 4'd0;
         r_sw_s    <= 4'd0;
         r_sw_prev <= 4'd0;
      end else begin
         r_sw_meta <= sw;
         r_sw_s    <= r_sw_meta;
         r_sw_prev <= r_sw_s;
      end
   end

   assign w_mode     = mode_t'(r_sw_s[1:0]);
   assign w_speed    = speed_t'(r_sw_s[3:2]);
   assign w_mode_chg = (r_sw_s[1:0] != r_sw_prev[1:0]);
   assign w_spd_chg  = (r_sw_s[3:2] != r_sw_prev[3:2]);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A mode change outranks everything, including a pending step wrap
   always_comb begin
      w_next_state = ST_LOAD;
      if (!w_mode_chg) begin
         case (r_state)
            ST_LOAD, ST_RUN: w_next_state = (w_speed == HOLD) ? ST_PAUSE : ST_RUN;
            ST_PAUSE:        w_next_state = (w_speed == HOLD) ? ST_PAUSE : ST_RUN;
            default:         w_next_state = ST_LOAD;
         endcase
      end
   end

   always_comb begin
      w_period = P_NORM;
      case (w_speed)
         FAST:    w_period = P_FAST;
         SLOW:    w_period = P_SLOW;
         default: w_period = P_NORM;
      endcase
   end

   // Any switch change restarts the period; PAUSE simply stops counting
   assign w_run   = (r_state == ST_RUN);
   assign w_clear = (r_state == ST_LOAD) || w_mode_chg || w_spd_chg;

   step_timer u_step_timer (
      .clk_in (clk_in),
      .rst    (rst),
      .period (w_period),
      .run    (w_run),
      .clear  (w_clear),
      .wrap   (w_wrap)
   );

   always_comb begin
      w_led_step = r_led;
      w_dir_step = r_dir_left;
      case (w_mode)
         ROT_L: w_led_step = {r_led[LED_W-2:0], r_led[LED_W-1]};
         ROT_R: w_led_step = {r_led[0], r_led[LED_W-1:1]};
         PINGPONG: begin
            if (r_dir_left) begin
               if (r_led == LED_W'(SEED_HI)) begin
                  w_led_step = r_led >> 1;
                  w_dir_step = 1'b0;
               end else begin
                  w_led_step = r_led << 1;
               end
            end else begin
               if (r_led == LED_W'(SEED_LO)) begin
                  w_led_step = r_led << 1;
                  w_dir_step = 1'b1;
               end else begin
                  w_led_step = r_led >> 1;
               end
            end
         end
         BLINK: w_led_step = ~r_led;
         default: w_led_step = r_led;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_led      <= '0;
         r_dir_left <= 1'b1;
         r_step     <= 1'b0;
      end else begin
         r_step <= w_wrap;
         if (r_state == ST_LOAD) begin
            r_led      <= LED_W'(seed_for(w_mode));
            r_dir_left <= 1'b1;
         end else if (w_wrap) begin
            r_led      <= w_led_step;
            r_dir_left <= w_dir_step;
         end
      end
   end

   assign led     = r_led;
   assign step    = r_step;
   assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_led_shift_ctrl.sv
// ------------------------------------------------------------------
// tb_led_shift_ctrl : directed vector bench for led_shift_ctrl
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_led_shift_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sw  = 4'b0000;
   logic [7:0] led;
   logic       step;
   logic [1:0] state_o;

   logic       rst3 = 1'b1;
   logic [3:0] sw3  = 4'b0000;
   logic [7:0] led3;
   logic       step3;
   logic [1:0] state3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   led_shift_ctrl #(.BASE_DIV(4), .LED_W(8)) dut (
      .clk_in (clk),
      .rst    (rst),
      .sw     (sw),
      .led    (led),
      .step   (step),
      .state_o(state_o)
   );

   led_shift_ctrl #(.BASE_DIV(3), .LED_W(8)) dut3 (
      .clk_in (clk),
      .rst    (rst3),
      .sw     (sw3),
      .led    (led3),
      .step   (step3),
      .state_o(state3)
   );

   typedef struct {
      logic       rst;
      logic [3:0] sw;
      int         n;
      logic [7:0] led;
      logic       step;
      logic [1:0] st;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [3:0] s, input int n,
                      input logic [7:0] l, input logic stp, input logic [1:0] q);
      vec_t v;
      v.rst = r; v.sw = s; v.n = n; v.led = l; v.step = stp; v.st = q;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
      end
   endtask

   logic [7:0] pp [15];
   logic [7:0] exp3;

   initial begin
      pp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

      // rotate-left walk from reset
      add(1, 4'b0000, 2, 8'h00, 0, 2'b00);
      add(0, 4'b0000, 1, 8'h01, 0, 2'b01);
      add(0, 4'b0000, 3, 8'h01, 0, 2'b01);
      add(0, 4'b0000, 1, 8'h02, 1, 2'b01);
      add(0, 4'b0000, 1, 8'h02, 0, 2'b01);
      add(0, 4'b0000, 3, 8'h04, 1, 2'b01);
      add(0, 4'b0000, 4, 8'h08, 1, 2'b01);
      add(0, 4'b0000, 4, 8'h10, 1, 2'b01);
      add(0, 4'b0000, 4, 8'h20, 1, 2'b01);
      add(0, 4'b0000, 4, 8'h40, 1, 2'b01);
      add(0, 4'b0000, 4, 8'h80, 1, 2'b01);
      add(0, 4'b0000, 4, 8'h01, 1, 2'b01);
      // pause for 50 cycles, then resume at slow speed
      add(0, 4'b1100, 2, 8'h01, 0, 2'b01);
      add(0, 4'b1100, 1, 8'h01, 0, 2'b10);
      add(0, 4'b1100, 25, 8'h01, 0, 2'b10);
      add(0, 4'b1100, 25, 8'h01, 0, 2'b10);
      add(0, 4'b1000, 3, 8'h01, 0, 2'b01);
      add(0, 4'b1000, 7, 8'h01, 0, 2'b01);
      add(0, 4'b1000, 1, 8'h02, 1, 2'b01);
      // back to normal speed, then mode change landing on a due wrap
      add(0, 4'b0000, 3, 8'h02, 0, 2'b01);
      add(0, 4'b0000, 4, 8'h04, 1, 2'b01);
      add(0, 4'b0000, 1, 8'h04, 0, 2'b01);
      add(0, 4'b0001, 2, 8'h04, 0, 2'b01);
      add(0, 4'b0001, 1, 8'h04, 0, 2'b00);
      add(0, 4'b0001, 1, 8'h80, 0, 2'b01);
      add(0, 4'b0001, 3, 8'h80, 0, 2'b01);
      add(0, 4'b0001, 1, 8'h40, 1, 2'b01);
      // blink, then a one-cycle reset mid-run
      add(0, 4'b0011, 3, 8'h40, 0, 2'b00);
      add(0, 4'b0011, 1, 8'hFF, 0, 2'b01);
      add(0, 4'b0011, 2, 8'hFF, 0, 2'b01);
      add(1, 4'b0011, 1, 8'h00, 0, 2'b00);
      add(0, 4'b0011, 1, 8'h01, 0, 2'b01);
      add(0, 4'b0011, 2, 8'h01, 0, 2'b00);
      add(0, 4'b0011, 1, 8'hFF, 0, 2'b01);
      add(0, 4'b0011, 4, 8'h00, 1, 2'b01);
      add(0, 4'b0011, 4, 8'hFF, 1, 2'b01);
      // ping-pong from reset
      add(1, 4'b0010, 2, 8'h00, 0, 2'b00);
      add(0, 4'b0010, 1, 8'h01, 0, 2'b01);
      add(0, 4'b0010, 2, 8'h01, 0, 2'b00);
      add(0, 4'b0010, 1, 8'h01, 0, 2'b01);
      for (int k = 0; k < 15; k++) add(0, 4'b0010, 4, pp[k], 1, 2'b01);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst;
         sw  = tbl[i].sw;
         for (int c = 0; c < tbl[i].n; c++) begin
            tick();
            if (c < tbl[i].n - 1) chk("step_idle", i, {7'd0, step}, 8'h00);
         end
         chk("led",   i, led, tbl[i].led);
         chk("step",  i, {7'd0, step}, {7'd0, tbl[i].step});
         chk("state", i, {6'd0, state_o}, {6'd0, tbl[i].st});
      end

      // fast speed with BASE_DIV=3 floors the period to one cycle
      rst3 = 1'b1;
      sw3  = 4'b0100;
      tick(); tick();
      chk("fast_rst_led", 0, led3, 8'h00);
      rst3 = 1'b0;
      tick();
      chk("fast_load_led", 0, led3, 8'h01);
      chk("fast_load_st", 0, {6'd0, state3}, 8'h01);
      tick(); tick();
      chk("fast_pre_led", 0, led3, 8'h01);
      chk("fast_pre_step", 0, {7'd0, step3}, 8'h00);
      exp3 = 8'h01;
      for (int k = 0; k < 8; k++) begin
         tick();
         exp3 = {exp3[6:0], exp3[7]};
         chk("fast_led", k, led3, exp3);
         chk("fast_step", k, {7'd0, step3}, 8'h01);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/led_shift_ctrl.md
LED_SHIFT_CTRL -- requirements
Module: led_shift_ctrl

Interface
REQ-001 Parameter BASE_DIV, default 12_500_000, clk_in cycles per step at normal speed (10 Hz from 125 MHz); legal range 2..2^30.
REQ-002 Parameter LED_W, default 8, LED bus width; fixed at 8 in this revision.
REQ-003 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous to clk_in and active-high.
REQ-005 sw  input  4  raw board switches, asynchronous; sw[1:0] mode, sw[3:2] speed.
REQ-006 led  output  8  LED pattern, registered.
REQ-007 step  output  1  one-cycle pulse, high in the same cycle led takes a RUN-state update.
REQ-008 state_o  output  2  current FSM state code, for debug.

Function
REQ-009 sw shall pass through a 2-flop synchronizer; all logic uses only the synchronized value sw_s.
REQ-010 The FSM shall have states LOAD (00), RUN (01) and PAUSE (10); code 11 is unused and shall recover to LOAD.
REQ-011 LOAD shall last exactly one cycle:
  - seeds led by sw_s[1:0]: 00 -> 0x01, 01 -> 0x80, 10 -> 0x01 with direction left, 11 -> 0xFF.
  - clears the step counter.
  - exits to PAUSE if sw_s[3:2]==11, else to RUN.
REQ-012 Step period by sw_s[3:2]: 00 = BASE_DIV, 01 = BASE_DIV/2 (floor, minimum 1), 10 = BASE_DIV*2, 11 = pause.
REQ-013 RUN counter:
  - counts 0..period-1, then wraps to 0 on the next cycle.
  - the wrap cycle updates led and asserts step.
  - the first update comes exactly period cycles after entry to RUN.
REQ-014 Mode 00 shall rotate led left by one (0x80 -> 0x01); mode 01 shall rotate right (0x01 -> 0x80).
REQ-015 Mode 10 (ping-pong): led shall shift in the current direction.
  - moving left at 0x80: next value 0x40, direction becomes right.
  - moving right at 0x01: next value 0x02, direction becomes left.
  - no dwell at either end.
REQ-016 Mode 11 shall invert led on each step (0xFF <-> 0x00).
REQ-017 PAUSE shall hold led, counter and direction, with step low.
REQ-018 Leaving PAUSE on a speed change to non-11 with the same mode shall enter RUN with the counter cleared and led retained.
REQ-019 A change of sw_s[1:0] (mode) between consecutive cycles shall force LOAD on the next cycle from any state.
REQ-020 A change of sw_s[3:2] only, from RUN, shall clear the counter and keep led and direction; to 11 it shall enter PAUSE.
REQ-021 Simultaneous mode and speed change: mode wins (LOAD), and LOAD then applies REQ-011 using the new speed.
REQ-022 If a step wrap coincides with a mode change, LOAD wins, no led update occurs and step stays low.
REQ-023 The counter shall be 32 bits; period arithmetic shall not overflow for legal BASE_DIV.

Reset
REQ-024 While rst is high at a clock edge:
  - led = 0x00, step = 0, counter = 0, direction = left.
  - synchronizer flops = 0, change-detect register = 0.
  - state = LOAD.
REQ-025 Asserting rst mid-RUN or mid-PAUSE shall abort immediately; the first cycle after release is LOAD using the current sw_s.

Structure
REQ-026 A shared package shall hold:
  - state codes LOAD/RUN/PAUSE.
  - mode codes ROT_L/ROT_R/PINGPONG/BLINK.
  - speed codes NORM/FAST/SLOW/HOLD.
  - the seed constants 0x01/0x80/0xFF.
REQ-027 Step timing shall live in one sub-module, step_timer.
  - inputs: clk_in, rst, period, run, clear.
  - output: one-cycle wrap pulse.
  - led_shift_ctrl owns the synchronizer, FSM and pattern register.

Verification (BASE_DIV=4)
REQ-028 Reset then release, sw=0000:
  - led=0x00 during reset, 0x01 the cycle after LOAD.
  - then 0x02, 0x04 ... 0x80, 0x01 every 4 cycles, with step high on each update.
REQ-029 sw=0010 (ping-pong) from reset: led sequence 0x01..0x80, 0x40..0x01, 0x02 with no repeated value at either end.
REQ-030 In RUN with mode 00, set sw[3:2]=11:
  - led freezes and step stays low for 50 cycles.
  - set sw[3:2]=10: the next update arrives exactly 8 cycles after RUN re-entry, continuing from the frozen value.
REQ-031 Change mode 00 -> 01 on the exact cycle a step wrap is due: no step pulse, LOAD seeds 0x80, next update 0x40 four cycles later.
REQ-032 Assert rst for one cycle mid-RUN in mode 11: led=0x00, then LOAD gives 0xFF, then it toggles 0x00/0xFF every 4 cycles.
REQ-033 Speed 01 with BASE_DIV=3: period floors to 1, so led updates every cycle with step held high continuously.
